// File: rtl/nibble_serial_add_if.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_add_if
//  Description : Request/result bundle for the nibble-serial adder.
//                The master side drives the operands and start strobe; the
//                slave side returns the held result and status flags.
//  Revision    : 1.0  initial release
// ============================================================================
interface nibble_serial_add_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         strt;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         cin;
  logic [W-1:0] sum;
  logic         co;
  logic         busy;
  logic         done;

  modport master (
    output strt, A, B, cin,
    input  sum, co, busy, done
  );

  modport slave (
    input  strt, A, B, cin,
    output sum, co, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_add.sv
`default_nettype none
// ============================================================================
//  Module      : adder4 / nibble_serial_add
//  Description : adder4 is a 4-bit ripple-carry adder slice.
//                nibble_serial_add reuses one adder4 to add two
//                4*NIBBLES-bit operands plus carry-in, one nibble per clock,
//                least-significant nibble first, with the carry held in a
//                register between nibbles.
//  Revision    : 1.0  initial release
// ============================================================================

module adder4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       co
);
  // Ripple the carry through the four bit positions.
  always_comb begin
    logic c;
    c   = cin;
    sum = 4'd0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = A[i] ^ B[i] ^ c;
      c      = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
    co = c;
  end
endmodule

module nibble_serial_add #(
  parameter int NIBBLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  nibble_serial_add_if.slave bus
);
  localparam int              W        = 4 * NIBBLES;
  localparam int              CW       = $clog2(NIBBLES) + 1;
  localparam logic [CW-1:0]   c_LAST   = CW'(NIBBLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_load;
  logic          w_step;
  logic          w_last;

  logic [W-1:0]  r_sha;
  logic [W-1:0]  r_shb;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_partial;
  logic [W-1:0]  r_sum;
  logic          r_co;
  logic          r_done;

  logic [3:0]    w_slice_sum;
  logic          w_slice_co;
  logic [W-1:0]  w_partial_nxt;
  logic          w_unused;

  // The single shared slice always works on the current low nibbles.
  adder4 u_slice (
    .A   (r_sha[3:0]),
    .B   (r_shb[3:0]),
    .cin (r_carry),
    .sum (w_slice_sum),
    .co  (w_slice_co)
  );

  // Newest nibble enters at the top so that after NIBBLES steps the
  // least-significant nibble has drifted down to bit 0.
  assign w_partial_nxt = {w_slice_sum, r_partial[W-1:4]};

  // The bottom nibble of the partial register is always shifted out unread.
  assign w_unused = &{1'b0, r_partial[3:0]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and step control: accept a start only while idle, finish
  // on the step that handles the most-significant nibble.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.strt) begin
          w_load      = 1'b1;
          w_state_nxt = ADD;
        end
      end
      ADD: begin
        w_step = 1'b1;
        if (r_cnt == c_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, per-nibble shifting, and the held result
  // which only changes on the completing step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sha     <= '0;
      r_shb     <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_partial <= '0;
      r_sum     <= '0;
      r_co      <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_sha   <= bus.A;
        r_shb   <= bus.B;
        r_carry <= bus.cin;
        r_cnt   <= '0;
      end else if (w_step) begin
        r_sha     <= r_sha >> 4;
        r_shb     <= r_shb >> 4;
        r_carry   <= w_slice_co;
        r_cnt     <= r_cnt + 1'b1;
        r_partial <= w_partial_nxt;
      end
      if (w_last) begin
        r_sum <= w_partial_nxt;
        r_co  <= w_slice_co;
      end
    end
  end

  assign bus.sum  = r_sum;
  assign bus.co   = r_co;
  assign bus.done = r_done;
  assign bus.busy = (r_state == ADD);
endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_add.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_add
//  Description : Self-checking bench for nibble_serial_add (16-bit build).
//                Results are compared against a plain W+1-bit arithmetic
//                model of A + B + cin.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nibble_serial_add;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  nibble_serial_add_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_add #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // Starts an add from the current negedge and waits for done (bounded).
  // Returns latency in cycles, busy-cycle count, whether the old result was
  // held while busy, and a timeout flag. With noise set, strt is re-pulsed
  // with other operands during the add.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input bit noise, output int lat, output int bcnt,
                       output bit held, output bit to);
    logic [W-1:0] s0;
    logic         c0;
    s0   = bus.sum;
    c0   = bus.co;
    held = 1'b1;
    lat  = 0;
    bcnt = 0;
    to   = 1'b1;
    bus.strt = 1'b1;
    bus.A    = a;
    bus.B    = b;
    bus.cin  = c;
    @(negedge clk);
    bus.strt = 1'b0;
    bus.A    = W'($urandom);
    bus.B    = W'($urandom);
    bus.cin  = 1'($urandom);
    for (int i = 0; i < NIBBLES + 20; i++) begin
      if (bus.done) begin
        to = 1'b0;
        break;
      end
      if (bus.busy) bcnt++;
      if (bus.sum !== s0 || bus.co !== c0) held = 1'b0;
      if (noise && i < NIBBLES - 1) begin
        bus.strt = 1'b1;
        bus.A    = 16'hAAAA;
        bus.B    = 16'h5555;
      end else begin
        bus.strt = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.strt = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done, bus.co} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags got busy/done/co=%b want 000", {bus.busy, bus.done, bus.co});
    end
    vectors++;
    if (bus.sum !== '0) begin
      miscompares++;
      $display("FAIL reset_sum got %h want 0000", bus.sum);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_ripple();
    int lat, bcnt; bit held, to;
    logic [W:0] exp;
    exp = model(16'hFFFF, 16'h0001, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bcnt, held, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL ripple_timeout got no done want done");
    end
    vectors++;
    if (lat != NIBBLES) begin
      miscompares++;
      $display("FAIL ripple_latency got %0d want %0d", lat, NIBBLES);
    end
    vectors++;
    if (bcnt != NIBBLES) begin
      miscompares++;
      $display("FAIL ripple_busy_cycles got %0d want %0d", bcnt, NIBBLES);
    end
    vectors++;
    if ({bus.co, bus.sum} !== exp) begin
      miscompares++;
      $display("FAIL ripple_result got %h want %h", {bus.co, bus.sum}, exp);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ripple_busy_at_done got %b want 0", bus.busy);
    end
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_width got %b want 0", bus.done);
    end
  endtask

  task automatic test_plain();
    int lat, bcnt; bit held, to;
    @(negedge clk);
    do_op(16'h1234, 16'h4321, 1'b1, 1'b0, lat, bcnt, held, to);
    vectors++;
    if (to || {bus.co, bus.sum} !== 17'h05556) begin
      miscompares++;
      $display("FAIL plain_cin got %h want 05556", {bus.co, bus.sum});
    end
    @(negedge clk);
    do_op(16'h0FFF, 16'h0000, 1'b1, 1'b0, lat, bcnt, held, to);
    vectors++;
    if (to || {bus.co, bus.sum} !== model(16'h0FFF, 16'h0000, 1'b1)) begin
      miscompares++;
      $display("FAIL plain_carry_chain got %h want %h", {bus.co, bus.sum},
               model(16'h0FFF, 16'h0000, 1'b1));
    end
  endtask

  task automatic test_overflow();
    int lat, bcnt; bit held, to;
    @(negedge clk);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, lat, bcnt, held, to);
    vectors++;
    if (to || {bus.co, bus.sum} !== 17'h10000) begin
      miscompares++;
      $display("FAIL overflow_top got %h want 10000", {bus.co, bus.sum});
    end
    @(negedge clk);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, lat, bcnt, held, to);
    vectors++;
    if (to || {bus.co, bus.sum} !== 17'h1FFFF) begin
      miscompares++;
      $display("FAIL overflow_max got %h want 1ffff", {bus.co, bus.sum});
    end
  endtask

  task automatic test_strt_busy();
    int lat, bcnt, extra; bit held, to;
    @(negedge clk);
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b1, lat, bcnt, held, to);
    vectors++;
    if (to || lat != NIBBLES) begin
      miscompares++;
      $display("FAIL busy_strt_latency got %0d want %0d", lat, NIBBLES);
    end
    vectors++;
    if ({bus.co, bus.sum} !== 17'h00100) begin
      miscompares++;
      $display("FAIL busy_strt_result got %h want 00100", {bus.co, bus.sum});
    end
    extra = 0;
    repeat (2 * NIBBLES + 2) begin
      @(negedge clk);
      if (bus.done || bus.busy) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL busy_strt_restart got %0d active cycles want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt; bit held, to;
    @(negedge clk);
    do_op(16'h1234, 16'h4321, 1'b1, 1'b0, lat, bcnt, held, to);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, bcnt, held, to);
    vectors++;
    if (!held) begin
      miscompares++;
      $display("FAIL b2b_hold got changed want held 5556");
    end
    vectors++;
    if (to || lat != NIBBLES || bcnt != NIBBLES) begin
      miscompares++;
      $display("FAIL b2b_timing got lat=%0d busy=%0d want %0d", lat, bcnt, NIBBLES);
    end
    vectors++;
    if ({bus.co, bus.sum} !== 17'h08000) begin
      miscompares++;
      $display("FAIL b2b_result got %h want 08000", {bus.co, bus.sum});
    end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt; bit held, to;
    @(negedge clk);
    bus.strt = 1'b1;
    bus.A    = 16'h1111;
    bus.B    = 16'h2222;
    bus.cin  = 1'b0;
    @(negedge clk);
    bus.strt = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.co, bus.sum} !== '0) begin
      miscompares++;
      $display("FAIL async_reset got busy/done/co/sum=%b%b%b/%h want all 0",
               bus.busy, bus.done, bus.co, bus.sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stale got done/busy=%b%b want 00", bus.done, bus.busy);
    end
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, lat, bcnt, held, to);
    vectors++;
    if (to || lat != NIBBLES || {bus.co, bus.sum} !== 17'h00002) begin
      miscompares++;
      $display("FAIL after_reset got lat=%0d res=%h want lat=%0d res=00002",
               lat, {bus.co, bus.sum}, NIBBLES);
    end
  endtask

  task automatic test_random();
    int lat, bcnt; bit held, to;
    logic [W-1:0] a, b;
    logic c;
    logic [W:0] exp;
    for (int i = 0; i < 256; i++) begin
      a      = W'($urandom);
      b      = W'($urandom);
      a[3:0] = 4'(i >> 4);
      b[3:0] = 4'(i);
      c      = 1'($urandom_range(0, 1));
      exp    = model(a, b, c);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      do_op(a, b, c, 1'b0, lat, bcnt, held, to);
      vectors++;
      if (to || lat != NIBBLES) begin
        miscompares++;
        $display("FAIL rand_latency[%0d] got %0d want %0d", i, lat, NIBBLES);
      end
      vectors++;
      if ({bus.co, bus.sum} !== exp) begin
        miscompares++;
        $display("FAIL rand_result[%0d] %h+%h+%b got %h want %h",
                 i, a, b, c, {bus.co, bus.sum}, exp);
      end
    end
  endtask

  initial begin
    bus.strt = 1'b0;
    bus.A    = '0;
    bus.B    = '0;
    bus.cin  = 1'b0;
    test_reset();
    test_ripple();
    test_plain();
    test_overflow();
    test_strt_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire

// File: doc/nibble_serial_add.md
Name: nibble_serial_add

Overview:
- Multi-cycle sequential wrapper that performs a 4*NIBBLES-bit add of A + B + cin.
- It reuses a single 4-bit ripple adder slice, one nibble per clock, least-significant nibble first.
- The carry is registered between cycles.
- It sits directly downstream of the 4-bit adder: it instantiates the adder (ports A[3:0], B[3:0], cin, sum[3:0], co) and consumes its sum/co every cycle.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand/result width W = 4*NIBBLES (legal range 2..8)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
strt  input  1  start request, sampled on rising edge while idle
A  input  W  operand A, sampled only on accepted strt
B  input  W  operand B, sampled only on accepted strt
cin  input  1  carry-in, sampled only on accepted strt
sum  output  W  registered result, held until next completion
co  output  1  registered final carry-out, held until next completion
busy  output  1  high while an add is in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-operation):
  - state=IDLE; busy=0, done=0, sum=0, co=0.
  - Internal operand shift regs, carry reg and nibble counter = 0.
  - An in-flight add is abandoned with no done pulse.
- States: IDLE, ADD.
- IDLE:
  - strt=1 at edge k: load A, B into shift regs; carry_reg<=cin; cnt<=0; state<=ADD; busy=1 from edge k.
  - strt=0: remain in IDLE.
- ADD, each edge:
  - Adder slice sees shiftA[3:0], shiftB[3:0], carry_reg.
  - Nibble sum shifts into the top of the partial-sum reg (partial <= {slice_sum, partial[W-1:4]}).
  - carry_reg<=slice_co; shiftA, shiftB shift right by 4; cnt<=cnt+1.
  - Counter width is ceil(log2(NIBBLES))+1 bits; no wrap occurs inside an operation.
- Completion:
  - On the edge where cnt==NIBBLES-1 (edge k+NIBBLES), the final nibble is processed.
  - sum<={slice_sum, partial[W-1:4]}; co<=slice_co; done<=1; busy<=0; state<=IDLE.
- Latency: strt accepted at edge k -> done high during the cycle after edge k+NIBBLES (exactly NIBBLES ADD cycles).
- done: high for exactly one cycle, cleared at the next edge.
- sum/co:
  - Change only at completion or reset.
  - Stable and valid whenever busy=0 after the first completion.
  - Never show partial values.
- strt while busy=1: ignored; no re-latch, no restart, in-flight result unaffected.
- strt during the done cycle: state is IDLE, so it is accepted at that edge.
  - Back-to-back operations run with zero dead cycles.
  - The new operation does not disturb sum/co until its own completion.
- A, B, cin are don't-care except at the accepting edge.
  - Changing them mid-operation must not affect the result.
- Arithmetic: {co,sum} == A + B + cin, computed to W+1 bits; all unsigned, no overflow flag.
- The carry chain propagates across nibble boundaries only via carry_reg; no combinational path from inputs to outputs.

Test Plan:
- Carry ripple across all nibbles:
  - Stimulus: reset, then strt with A=16'hFFFF, B=16'h0001, cin=0.
  - Required: busy high 4 cycles; done pulses one cycle 4 edges after acceptance; sum=16'h0000, co=1.
- Plain add with carry-in:
  - Stimulus: A=16'h1234, B=16'h4321, cin=1.
  - Required: sum=16'h5556, co=0.
  - Stimulus: A=16'h0FFF, B=16'h0000, cin=1.
  - Required: sum=16'h1000, co=0.
- Top-bit overflow:
  - Stimulus: A=16'h8000, B=16'h8000, cin=0.
  - Required: sum=16'h0000, co=1.
  - Then A=16'hFFFF, B=16'hFFFF, cin=1.
  - Required: sum=16'hFFFF, co=1.
- strt while busy:
  - Stimulus: start 16'h00FF+16'h0001; pulse strt with A=16'hAAAA, B=16'h5555 at cycles 1–3 of the add.
  - Required: single done; sum=16'h0100, co=0.
- Back-to-back:
  - Stimulus: strt asserted in the done cycle with A=16'h7FFF, B=16'h0001.
  - Required: previous sum held through the 4 busy cycles; next done shows sum=16'h8000, co=0.
- Reset mid-operation:
  - Stimulus: drop rst_n asynchronously (between edges) during the 2nd ADD cycle.
  - Required: busy/done/sum/co go to 0 immediately.
  - Then release rst_n and run a new add of 16'h0001+16'h0001.
  - Required: sum=16'h0002, co=0, with no stale done.
- Exhaustive check: a randomized/exhaustive low-nibble sweep compares against a W+1-bit golden model after every done pulse.
